booth2_final_adder: RTL and testbench
=====================================

// Module: booth2_final_adder
// PURPOSE
//  Final carry-propagate stage of the 16x16 Booth-2/Wallace multiplier.
//  - Consumes the two partial products left by the 4:2/3:2 compressor tree:
//    - pp1_in: 32b, weight 2^0.
//    - pp2_in: 30b, weight 2^2. It is zero-extended by 2 LSBs before the add.
//  - Produces the 32b product through a 2-stage carry-split pipeline with valid/ready handshakes.
// PARAMETERS
//  SPLIT_W  16  width of low segment added in stage 1; legal 1..31; high segment = 32-SPLIT_W
//  CNT_W    16  width of prod_cnt (used only with FA_CNT_EN)
// PORTS
//  sys_clk    in   1   clock, all state on rising edge
//  sys_rst    in   1   synchronous reset, active-high
//  in_valid   in   1   pp1_in/pp2_in valid
//  in_ready   out  1   stage 1 can accept
//  pp1_in     in   32  compressed partial product 1 (weight 2^0)
//  pp2_in     in   30  compressed partial product 2 (weight 2^2)
//  out_valid  out  1   product valid
//  out_ready  in   1   downstream accepts product
//  product    out  32  (pp1_in + {pp2_in,2'b0}) mod 2^32
//  prod_cnt   out  CNT_W  completed-product counter (only with FA_CNT_EN)
// BEHAVIOUR
//  - Operand alignment: B = {pp2_in,2'b00}. A = pp1_in. Result = (A+B) mod 2^32.
//    The carry out of bit 31 is discarded.
//  - Stage 1 (s1), on accept:
//    - registers s1_lo = A[SPLIT_W-1:0]+B[SPLIT_W-1:0] (SPLIT_W bits)
//    - registers s1_c = carry out of that low add
//    - registers A_hi and B_hi unchanged
//    - sets s1_valid.
//  - Stage 2 (s2), on advance:
//    - registers product = {A_hi+B_hi+s1_c, s1_lo}
//    - sets s2_valid; out_valid = s2_valid.
//  - Handshake and stall logic:
//    - s2_en = ~s2_valid | out_ready
//    - s1_en = ~s1_valid | s2_en
//    - in_ready = s1_en & ~sys_rst
//  - Transfers:
//    - Input transfer = in_valid & in_ready.
//    - Output transfer = out_valid & out_ready.
//    - s1 -> s2 move = s1_valid & s2_en.
//    - When s2_en=1 and s1_valid=0, s2_valid clears.
//  - Latency: exactly 2 cycles from input transfer to out_valid when unstalled.
//    Throughput is 1 product/cycle.
//  - Full stall: with out_ready=0, both stages fill after 2 accepts. in_ready then drops.
//    product and out_valid hold stable until out_ready=1. No data is dropped or duplicated.
//  - Simultaneous events: if out_ready=1 while the pipe is full, s2 takes s1 and s1 takes the
//    new input in the same edge. in_ready stays 1.
//  - Data-path registers update only on their stage's advance; otherwise they hold.
//    Data registers need not be reset, except product.
//  - Reset (any cycle, including mid-operation):
//    - s1_valid=0, s2_valid=0, out_valid=0, product=0, prod_cnt=0.
//    - In-flight data is discarded.
//    - in_ready=0 during the reset cycle, 1 on the first cycle after.
//  - out_valid must never depend combinationally on out_ready (registered output).
// CONFIGURATION
//  - FA_CNT_EN defined:
//    - prod_cnt port and register exist.
//    - prod_cnt increments by 1 on each output transfer and wraps 2^CNT_W-1 -> 0.
//    - Reset value 0.
//  - FA_CNT_EN undefined:
//    - prod_cnt port and counter logic are absent.
//    - All other behaviour is identical.
// TESTING
//  - Carry across split: pp1=32'h0000FFFF, pp2=30'h1, out_ready=1.
//    Expect product=32'h00010003 exactly 2 cycles after accept.
//  - Top wrap: pp1=32'hFFFFFFFF, pp2=30'h1.
//    Expect product=32'h00000003 (carry out of bit 31 discarded).
//  - Back-to-back streaming: feed 5 vectors on consecutive cycles, out_ready=1.
//    Expect in_ready=1 throughout and 5 products in order on consecutive cycles.
//  - Backpressure: out_ready=0 while feeding 3 vectors.
//    Expect in_ready=0 after 2 accepts and product held stable.
//    Then raise out_ready: all 3 products emerge in order with none lost.
//  - Reset mid-operation: assert sys_rst for 1 cycle while both stages are valid.
//    Expect out_valid=0 and product=0 next cycle, no stale output afterwards, in_ready=1 after.
//  - FA_CNT_EN with CNT_W=4: perform 17 output transfers.
//    Expect prod_cnt to reach 4'hF, wrap to 0, then read 1. It holds during stalls.
//  - Random: 10k random 16x16 signed operands pushed through the Booth generator and compressor.
//    Random valid/ready toggling. Compare against the a*b golden model.

Source files
------------

// File: rtl/booth2_final_adder.sv
// Final carry-propagate adder of the 16x16 Booth-2/Wallace multiplier.
// Two-stage carry-split pipeline; define FA_CNT_EN to add the prod_cnt counter.
module booth2_final_adder #(
    parameter int SPLIT_W = 16
`ifdef FA_CNT_EN
    ,
    parameter int CNT_W = 16
`endif
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       pp1_in,
    input  logic [29:0]       pp2_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       product
`ifdef FA_CNT_EN
    ,
    output logic [CNT_W-1:0]  prod_cnt
`endif
);

    localparam int HI_W = 32 - SPLIT_W;

    logic [31:0]        a_op;
    logic [31:0]        b_op;
    logic [SPLIT_W:0]   lo_sum;
    logic [HI_W-1:0]    hi_sum;

    logic               s1_valid;
    logic               s2_valid;
    logic               s1_en;
    logic               s2_en;
    logic               in_xfer;
    logic               s1_move;

    logic [SPLIT_W-1:0] s1_lo;
    logic               s1_c;
    logic [HI_W-1:0]    s1_ahi;
    logic [HI_W-1:0]    s1_bhi;

    assign a_op    = pp1_in;
    assign b_op    = {pp2_in, 2'b00};
    assign lo_sum  = {1'b0, a_op[SPLIT_W-1:0]} + {1'b0, b_op[SPLIT_W-1:0]};
    assign hi_sum  = s1_ahi + s1_bhi + HI_W'(s1_c);

    assign s2_en     = ~s2_valid | out_ready;
    assign s1_en     = ~s1_valid | s2_en;
    assign in_ready  = s1_en & ~sys_rst;
    assign in_xfer   = in_valid & in_ready;
    assign s1_move   = s1_valid & s2_en;
    assign out_valid = s2_valid;

    // Stage occupancy: each stage refills whenever it is allowed to advance
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else begin
            if (s1_en) begin
                s1_valid <= in_valid;
            end
            if (s2_en) begin
                s2_valid <= s1_valid;
            end
        end
    end

    // Stage 1 data: low segment summed now, high halves carried forward
    always_ff @(posedge sys_clk) begin
        if (in_xfer) begin
            s1_lo  <= lo_sum[SPLIT_W-1:0];
            s1_c   <= lo_sum[SPLIT_W];
            s1_ahi <= a_op[31:SPLIT_W];
            s1_bhi <= b_op[31:SPLIT_W];
        end
    end

    // Stage 2 data: high segment absorbs the low carry; bit-31 carry dropped
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            product <= '0;
        end else if (s1_move) begin
            product <= {hi_sum, s1_lo};
        end
    end

`ifdef FA_CNT_EN
    // Completed-product counter, wraps naturally at 2^CNT_W
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            prod_cnt <= '0;
        end else if (out_valid & out_ready) begin
            prod_cnt <= prod_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_booth2_final_adder.sv
// Bench for booth2_final_adder: directed vectors plus a queue-based
// reference of the pipe checked on every falling edge.
module tb_booth2_final_adder;

`ifdef FA_CNT_EN
    localparam int CW = 4;
`endif

    logic        sys_clk;
    logic        sys_rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] pp1_in;
    logic [29:0] pp2_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] product;
`ifdef FA_CNT_EN
    logic [CW-1:0] prod_cnt;
`endif

    booth2_final_adder #(
        .SPLIT_W(16)
`ifdef FA_CNT_EN
        ,
        .CNT_W(CW)
`endif
    ) dut (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .pp1_in   (pp1_in),
        .pp2_in   (pp2_in),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .product  (product)
`ifdef FA_CNT_EN
        ,
        .prod_cnt (prod_cnt)
`endif
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    int n_vec = 0;
    int n_bad = 0;
    int cyc = 0;

    // reference: products in flight with the cycle they entered stage 1
    logic [31:0] exp_q[$];
    int          acc_q[$];
    int          mdl_cnt = 0;
    bit          post_rst = 1'b0;

    function automatic logic [31:0] ref_sum(input logic [31:0] a,
                                            input logic [29:0] b);
        logic [63:0] s;
        s = 64'(a) + (64'(b) * 64'd4);
        return s[31:0];
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, req, $time);
        end
    endtask

    always @(posedge sys_clk) cyc++;

    // Per-cycle comparison against the reference, then advance it
    always @(negedge sys_clk) begin
        bit exp_ov;
        bit exp_ir;
        if (post_rst) begin
            chk("post_rst_product", product, 32'h0);
            post_rst = 1'b0;
        end
        exp_ov = (exp_q.size() > 0) && (cyc >= acc_q[0] + 1);
        exp_ir = !sys_rst && ((exp_q.size() < 2) || out_ready);
        chk("out_valid", {31'b0, out_valid}, {31'b0, exp_ov});
        chk("in_ready", {31'b0, in_ready}, {31'b0, exp_ir});
        if (exp_ov && out_valid === 1'b1) begin
            chk("product", product, exp_q[0]);
        end
`ifdef FA_CNT_EN
        chk("prod_cnt", 32'(prod_cnt), 32'(mdl_cnt % (1 << CW)));
`endif
        if (sys_rst) begin
            exp_q.delete();
            acc_q.delete();
            mdl_cnt  = 0;
            post_rst = 1'b1;
        end else begin
            if (out_valid && out_ready && exp_q.size() > 0) begin
                void'(exp_q.pop_front());
                void'(acc_q.pop_front());
                mdl_cnt++;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(ref_sum(pp1_in, pp2_in));
                acc_q.push_back(cyc + 1);
            end
        end
    end

    // present a vector and hold it until accepted (bounded)
    task automatic push(input logic [31:0] a, input logic [29:0] b);
        bit ok;
        in_valid = 1'b1;
        pp1_in   = a;
        pp2_in   = b;
        ok       = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge sys_clk);
            ok = in_ready;
            @(posedge sys_clk);
            #1;
        end
        if (!ok) begin
            n_vec++;
            n_bad++;
            $display("FAIL push_timeout: got no accept expected accept");
        end
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge sys_clk);
            #1;
        end
    endtask

    // single vector with hand-computed result and latency check
    task automatic send_one(input string nm, input logic [31:0] a,
                            input logic [29:0] b, input logic [31:0] req);
        int lat;
        out_ready = 1'b1;
        push(a, b);
        in_valid = 1'b0;
        lat = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge sys_clk);
            lat++;
            if (out_valid) break;
        end
        chk({nm, "_latency"}, 32'(lat), 32'd2);
        chk(nm, product, req);
        @(posedge sys_clk);
        #1;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        in_valid  = 1'b0;
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) begin
            @(posedge sys_clk);
            #1;
        end
        chk("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        logic [31:0] m;
        logic [29:0] x;
        logic [15:0] ua;
        logic [15:0] ub;
        sys_rst   = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        pp1_in    = '0;
        pp2_in    = '0;
        repeat (2) @(posedge sys_clk);
        #1;
        sys_rst = 1'b0;
        @(negedge sys_clk);
        chk("reset_product", product, 32'h0);
        chk("reset_out_valid", {31'b0, out_valid}, 32'h0);
        @(posedge sys_clk);
        #1;

        send_one("carry_split", 32'h0000FFFF, 30'h1, 32'h00010003);
        send_one("top_wrap", 32'hFFFFFFFF, 30'h1, 32'h00000003);
        send_one("pp2_top", 32'h00000001, 30'h3FFFFFFF, 32'hFFFFFFFD);
        send_one("mixed", 32'h12345678, 30'h01000000, 32'h16345678);

        // pp1/pp2 split of a real signed product: -3 * 7 = -21
        m = 32'hFFFFFFEB;
        x = 30'h00000005;
        send_one("mul_split", m - {x, 2'b00}, x, 32'hFFFFFFEB);

        // back-to-back streaming
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            push(32'h0001_0000 * i + 32'hFFFF, 30'(i + 1));
        end
        drain();

        // backpressure: three vectors, third waits for out_ready
        out_ready = 1'b0;
        push(32'hAAAA5555, 30'h11111111);
        push(32'h0000FFFE, 30'h00000001);
        in_valid = 1'b0;
        @(negedge sys_clk);
        chk("stall_in_ready", {31'b0, in_ready}, 32'h0);
        chk("stall_product", product, 32'hEEEE9999);
        @(posedge sys_clk);
        #1;
        fork
            push(32'h80000000, 30'h20000000);
            begin
                repeat (4) @(posedge sys_clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();

        // reset with both stages full
        out_ready = 1'b0;
        push(32'h11111111, 30'h2);
        push(32'h22222222, 30'h3);
        in_valid = 1'b0;
        sys_rst  = 1'b1;
        @(posedge sys_clk);
        #1;
        sys_rst = 1'b0;
        @(negedge sys_clk);
        chk("rst_mid_out_valid", {31'b0, out_valid}, 32'h0);
        chk("rst_mid_in_ready", {31'b0, in_ready}, 32'h1);
        out_ready = 1'b1;
        idle(4);

`ifdef FA_CNT_EN
        for (int i = 0; i < 17; i++) push(32'(i), 30'(i));
        drain();
        chk("cnt_wrap", 32'(prod_cnt), 32'h1);
`endif

        // randomized traffic including multiplier-derived splits
        for (int i = 0; i < 400; i++) begin
            ua = 16'($urandom);
            ub = 16'($urandom);
            m  = 32'($signed(ua) * $signed(ub));
            x  = 30'($urandom);
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 3) != 0);
            if (i % 2 == 0) begin
                pp1_in = m - {x, 2'b00};
                pp2_in = x;
            end else begin
                pp1_in = $urandom;
                pp2_in = x;
            end
            @(posedge sys_clk);
            #1;
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
